data_mem_ctrl: RTL and testbench

Access controller between the MEM pipeline stage and the byte-addressed, big-endian 256x8 data RAM. It accepts one load/store request at a time and sequences it into RAM beats: one word-or-smaller beat, or two word beats for a doubleword, since the RAM's own doubleword write is a no-op. It assembles the read data, flags misaligned or out-of-range accesses, and stalls the pipeline until the response is ready.

---
 rtl/data_mem_pkg.sv | 43 ++++
 rtl/mem_req_check.sv | 31 +++
 rtl/data_mem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data RAM access controller.
// Holds access-mode codes, the FSM state enum and size/extend helpers.
package data_mem_pkg;

   localparam logic [1:0] MODE_BYTE  = 2'b00;
   localparam logic [1:0] MODE_HALF  = 2'b01;
   localparam logic [1:0] MODE_WORD  = 2'b10;
   localparam logic [1:0] MODE_DWORD = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BEAT0,
      S_GAP,
      S_BEAT1,
      S_RESP
   } state_t;

   function automatic logic [3:0] size_bytes(input logic [1:0] mode);
      logic [3:0] n;
      unique case (mode)
         MODE_BYTE: n = 4'd1;
         MODE_HALF: n = 4'd2;
         MODE_WORD: n = 4'd4;
         MODE_DWORD: n = 4'd8;
      endcase
      return n;
   endfunction

   // Zero-extend a single-beat RAM read to the 64-bit response.
   function automatic logic [63:0] load_extend(
      input logic [1:0]  mode,
      input logic [31:0] d
   );
      logic [63:0] r;
      unique case (mode)
         MODE_BYTE: r = {56'd0, d[7:0]};
         MODE_HALF: r = {48'd0, d[15:0]};
         default:   r = {32'd0, d};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_req_check.sv
// Combinational alignment and range check for one access request.
// Ports: i_mode, i_addr in; o_err out (misaligned or addr+size > ADDR_LIMIT).
module mem_req_check
   import data_mem_pkg::*;
#(
   parameter int ADDR_LIMIT = 256
) (
   input  logic [1:0]  i_mode,
   input  logic [31:0] i_addr,
   output logic        o_err
);

   logic        w_misaligned;
   logic [32:0] w_end;

   always_comb begin
      w_misaligned = 1'b0;
      unique case (i_mode)
         MODE_BYTE:  w_misaligned = 1'b0;
         MODE_HALF:  w_misaligned = i_addr[0];
         MODE_WORD:  w_misaligned = |i_addr[1:0];
         MODE_DWORD: w_misaligned = |i_addr[2:0];
      endcase
   end

   // 33-bit sum so addresses near 2^32 cannot wrap into range.
   assign w_end = {1'b0, i_addr} + {29'd0, size_bytes(i_mode)};

   assign o_err = w_misaligned || (w_end > 33'(ADDR_LIMIT));

endmodule

// File: rtl/data_mem_ctrl.sv
// Sequences MEM-stage loads/stores into beats on a big-endian 256x8 RAM.
// Ports: i_req_* request, o_req_ready/o_stall, o_resp_* response, o_ram_*/i_ram_rdata RAM.
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int ADDR_LIMIT = 256
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   input  logic        i_req_rw,
   input  logic [1:0]  i_req_mode,
   input  logic [31:0] i_req_addr,
   input  logic [63:0] i_req_wdata,
   output logic        o_req_ready,
   output logic        o_resp_valid,
   output logic [63:0] o_resp_rdata,
   output logic        o_resp_err,
   output logic        o_stall,
   output logic        o_ram_enable,
   output logic        o_ram_rw,
   output logic [31:0] o_ram_addr,
   output logic [31:0] o_ram_wdata,
   output logic [1:0]  o_ram_mode,
   input  logic [31:0] i_ram_rdata
);

   state_t      r_state;
   logic        r_rw;
   logic [1:0]  r_mode;
   logic [31:0] r_addr;
   logic [31:0] r_wdata_lo;
   logic [31:0] r_rdata_hi;

   logic        r_resp_valid;
   logic [63:0] r_resp_rdata;
   logic        r_resp_err;
   logic        r_ram_enable;
   logic        r_ram_rw;
   logic [31:0] r_ram_addr;
   logic [31:0] r_ram_wdata;
   logic [1:0]  r_ram_mode;

   logic        w_err;
   logic        w_dword;

   mem_req_check #(
      .ADDR_LIMIT(ADDR_LIMIT)
   ) u_check (
      .i_mode(i_req_mode),
      .i_addr(i_req_addr),
      .o_err (w_err)
   );

   assign w_dword = (i_req_mode == MODE_DWORD);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_rw         <= 1'b0;
         r_mode       <= MODE_BYTE;
         r_addr       <= '0;
         r_wdata_lo   <= '0;
         r_rdata_hi   <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
         r_ram_enable <= 1'b0;
         r_ram_rw     <= 1'b0;
         r_ram_addr   <= '0;
         r_ram_wdata  <= '0;
         r_ram_mode   <= MODE_BYTE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_rw       <= i_req_rw;
                  r_mode     <= i_req_mode;
                  r_addr     <= i_req_addr;
                  r_wdata_lo <= i_req_wdata[31:0];
                  if (w_err) begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                     r_resp_rdata <= '0;
                  end else begin
                     r_state      <= S_BEAT0;
                     r_ram_enable <= 1'b1;
                     r_ram_rw     <= i_req_rw;
                     r_ram_addr   <= i_req_addr;
                     // Doubleword goes out as two word beats, high word first.
                     r_ram_mode   <= w_dword ? MODE_WORD : i_req_mode;
                     r_ram_wdata  <= w_dword ? i_req_wdata[63:32]
                                             : i_req_wdata[31:0];
                  end
               end
            end
            S_BEAT0: begin
               r_ram_enable <= 1'b0;
               r_ram_rw     <= 1'b0;
               r_ram_addr   <= '0;
               r_ram_wdata  <= '0;
               r_ram_mode   <= MODE_BYTE;
               if (r_mode == MODE_DWORD) begin
                  r_state    <= S_GAP;
                  r_rdata_hi <= r_rw ? 32'd0 : i_ram_rdata;
               end else begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= 1'b0;
                  r_resp_rdata <= r_rw ? 64'd0
                                       : load_extend(r_mode, i_ram_rdata);
               end
            end
            S_GAP: begin
               // Enable was low for this cycle so the RAM sees a new beat.
               r_state      <= S_BEAT1;
               r_ram_enable <= 1'b1;
               r_ram_rw     <= r_rw;
               r_ram_addr   <= r_addr + 32'd4;
               r_ram_wdata  <= r_wdata_lo;
               r_ram_mode   <= MODE_WORD;
            end
            S_BEAT1: begin
               r_state      <= S_RESP;
               r_ram_enable <= 1'b0;
               r_ram_rw     <= 1'b0;
               r_ram_addr   <= '0;
               r_ram_wdata  <= '0;
               r_ram_mode   <= MODE_BYTE;
               r_resp_valid <= 1'b1;
               r_resp_err   <= 1'b0;
               r_resp_rdata <= r_rw ? 64'd0 : {r_rdata_hi, i_ram_rdata};
            end
            S_RESP: begin
               r_state      <= S_IDLE;
               r_resp_valid <= 1'b0;
               r_resp_err   <= 1'b0;
               r_resp_rdata <= '0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_req_ready  = (r_state == S_IDLE) && !i_reset;
   assign o_stall      = !i_reset &&
                         (((r_state == S_IDLE) && i_req_valid) ||
                          (r_state == S_BEAT0) ||
                          (r_state == S_GAP) ||
                          (r_state == S_BEAT1));
   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_resp_rdata;
   assign o_resp_err   = r_resp_err;
   assign o_ram_enable = r_ram_enable;
   assign o_ram_rw     = r_ram_rw;
   assign o_ram_addr   = r_ram_addr;
   assign o_ram_wdata  = r_ram_wdata;
   assign o_ram_mode   = r_ram_mode;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a big-endian 256x8 RAM model.
// Ports: none; drives the controller and checks responses and RAM beats.
module tb_data_mem_ctrl;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_rw;
   logic [1:0]  req_mode;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        stall;
   logic        ram_enable;
   logic        ram_rw;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [1:0]  ram_mode;
   logic [31:0] ram_rdata;

   logic [7:0]  mem [256];

   int n_chk;
   int n_err;

   logic        tr_en    [16];
   logic        tr_rw    [16];
   logic [31:0] tr_addr  [16];
   logic [31:0] tr_wd    [16];
   logic [1:0]  tr_mode  [16];
   logic        tr_stall [16];
   int          lat;
   logic [63:0] rd;
   logic        er;

   data_mem_ctrl #(
      .ADDR_LIMIT(256)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_req_valid (req_valid),
      .i_req_rw    (req_rw),
      .i_req_mode  (req_mode),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .o_req_ready (req_ready),
      .o_resp_valid(resp_valid),
      .o_resp_rdata(resp_rdata),
      .o_resp_err  (resp_err),
      .o_stall     (stall),
      .o_ram_enable(ram_enable),
      .o_ram_rw    (ram_rw),
      .o_ram_addr  (ram_addr),
      .o_ram_wdata (ram_wdata),
      .o_ram_mode  (ram_mode),
      .i_ram_rdata (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: combinational read, write at the edge ending the beat.
   always_comb begin
      logic [7:0] a;
      a = ram_addr[7:0];
      ram_rdata = '0;
      if (ram_enable && !ram_rw) begin
         case (ram_mode)
            2'b00: ram_rdata = {24'd0, mem[a]};
            2'b01: ram_rdata = {16'd0, mem[a], mem[a + 8'd1]};
            2'b10: ram_rdata = {mem[a], mem[a + 8'd1],
                                mem[a + 8'd2], mem[a + 8'd3]};
            default: ram_rdata = '0;
         endcase
      end
   end

   always @(posedge clk) begin
      logic [7:0] a;
      a = ram_addr[7:0];
      if (ram_enable && ram_rw) begin
         case (ram_mode)
            2'b00: mem[a] <= ram_wdata[7:0];
            2'b01: begin
               mem[a]        <= ram_wdata[15:8];
               mem[a + 8'd1] <= ram_wdata[7:0];
            end
            2'b10: begin
               mem[a]        <= ram_wdata[31:24];
               mem[a + 8'd1] <= ram_wdata[23:16];
               mem[a + 8'd2] <= ram_wdata[15:8];
               mem[a + 8'd3] <= ram_wdata[7:0];
            end
            default: ;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_req(input logic rw, input logic [1:0] mode,
                         input logic [31:0] addr, input logic [63:0] wd);
      for (int i = 0; i < 16; i++) begin
         tr_en[i] = 0; tr_rw[i] = 0; tr_addr[i] = 0;
         tr_wd[i] = 0; tr_mode[i] = 0; tr_stall[i] = 0;
      end
      lat = 0;
      rd  = '0;
      er  = 1'b0;
      @(negedge clk);
      chk("ready_idle", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1;
      req_rw    = rw;
      req_mode  = mode;
      req_addr  = addr;
      req_wdata = wd;
      #1;
      chk("stall_req", {63'd0, stall}, 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         tr_en[c]    = ram_enable;
         tr_rw[c]    = ram_rw;
         tr_addr[c]  = ram_addr;
         tr_wd[c]    = ram_wdata;
         tr_mode[c]  = ram_mode;
         tr_stall[c] = stall;
         if (resp_valid) begin
            lat = c;
            rd  = resp_rdata;
            er  = resp_err;
            break;
         end
      end
      if (lat == 0) chk("timeout", 64'd0, 64'd1);
   endtask

   initial begin
      logic any_rv;
      n_chk = 0;
      n_err = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      for (int i = 0; i < 8; i++) mem[8'hF8 + i] = 8'hA0 + 8'(i);
      reset     = 1'b1;
      req_valid = 1'b0;
      req_rw    = 1'b0;
      req_mode  = 2'b00;
      req_addr  = '0;
      req_wdata = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      req_valid = 1'b1;
      req_mode  = 2'b10;
      #1;
      chk("rst_ready", {63'd0, req_ready}, 64'd0);
      chk("rst_stall", {63'd0, stall}, 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", {63'd0, req_ready}, 64'd1);
      chk("rst_no_beat", {63'd0, ram_enable}, 64'd0);
      chk("rst_no_resp", {63'd0, resp_valid}, 64'd0);

      // Word store then load
      do_req(1'b1, 2'b10, 32'h10, 64'hDEADBEEF);
      chk("ws_lat", 64'(lat), 64'd2);
      chk("ws_en", {63'd0, tr_en[1]}, 64'd1);
      chk("ws_rw", {63'd0, tr_rw[1]}, 64'd1);
      chk("ws_addr", {32'd0, tr_addr[1]}, 64'h10);
      chk("ws_wd", {32'd0, tr_wd[1]}, 64'hDEADBEEF);
      chk("ws_mode", {62'd0, tr_mode[1]}, 64'd2);
      chk("ws_rdata", rd, 64'd0);
      chk("ws_err", {63'd0, er}, 64'd0);
      chk("ws_stall_resp", {63'd0, tr_stall[2]}, 64'd0);

      do_req(1'b0, 2'b10, 32'h10, 64'd0);
      chk("wl_lat", 64'(lat), 64'd2);
      chk("wl_mode", {62'd0, tr_mode[1]}, 64'd2);
      chk("wl_stall_beat", {63'd0, tr_stall[1]}, 64'd1);
      chk("wl_rdata", rd, 64'h00000000_DEADBEEF);
      chk("wl_err", {63'd0, er}, 64'd0);

      // Doubleword store and load
      do_req(1'b1, 2'b11, 32'h20, 64'h01234567_89ABCDEF);
      chk("ds_lat", 64'(lat), 64'd4);
      chk("ds_en0", {63'd0, tr_en[1]}, 64'd1);
      chk("ds_addr0", {32'd0, tr_addr[1]}, 64'h20);
      chk("ds_wd0", {32'd0, tr_wd[1]}, 64'h01234567);
      chk("ds_mode0", {62'd0, tr_mode[1]}, 64'd2);
      chk("ds_gap", {63'd0, tr_en[2]}, 64'd0);
      chk("ds_gap_stall", {63'd0, tr_stall[2]}, 64'd1);
      chk("ds_en1", {63'd0, tr_en[3]}, 64'd1);
      chk("ds_addr1", {32'd0, tr_addr[3]}, 64'h24);
      chk("ds_wd1", {32'd0, tr_wd[3]}, 64'h89ABCDEF);
      chk("ds_mode1", {62'd0, tr_mode[3]}, 64'd2);

      do_req(1'b0, 2'b11, 32'h20, 64'd0);
      chk("dl_lat", 64'(lat), 64'd4);
      chk("dl_rdata", rd, 64'h01234567_89ABCDEF);

      // Sub-word loads on big-endian bytes 01 23 45 67 89 AB CD EF
      do_req(1'b0, 2'b00, 32'h23, 64'd0);
      chk("bl_rdata", rd, 64'h67);
      chk("bl_mode", {62'd0, tr_mode[1]}, 64'd0);
      do_req(1'b0, 2'b01, 32'h26, 64'd0);
      chk("hl26_rdata", rd, 64'hCDEF);
      do_req(1'b0, 2'b01, 32'h24, 64'd0);
      chk("hl24_rdata", rd, 64'h89AB);

      // Misaligned halfword store
      do_req(1'b1, 2'b01, 32'h11, 64'h5555);
      chk("hs_lat", 64'(lat), 64'd1);
      chk("hs_err", {63'd0, er}, 64'd1);
      chk("hs_no_en", {63'd0, tr_en[1]}, 64'd0);
      chk("hs_rdata", rd, 64'd0);
      do_req(1'b0, 2'b10, 32'h10, 64'd0);
      chk("mem_unchanged", rd, 64'hDEADBEEF);

      // Range boundaries
      do_req(1'b0, 2'b11, 32'hF8, 64'd0);
      chk("dF8_err", {63'd0, er}, 64'd0);
      chk("dF8_rdata", rd, 64'hA0A1A2A3_A4A5A6A7);
      do_req(1'b0, 2'b10, 32'hFC, 64'd0);
      chk("wFC_err", {63'd0, er}, 64'd0);
      chk("wFC_rdata", rd, 64'hA4A5A6A7);
      do_req(1'b0, 2'b11, 32'hFC, 64'd0);
      chk("dFC_err", {63'd0, er}, 64'd1);
      chk("dFC_lat", 64'(lat), 64'd1);
      do_req(1'b0, 2'b10, 32'h100, 64'd0);
      chk("w100_err", {63'd0, er}, 64'd1);
      chk("w100_no_en", {63'd0, tr_en[1]}, 64'd0);

      // Reset during GAP of a doubleword load
      @(negedge clk);
      req_valid = 1'b1;
      req_rw    = 1'b0;
      req_mode  = 2'b11;
      req_addr  = 32'h20;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rg_beat0", {63'd0, ram_enable}, 64'd1);
      @(negedge clk);
      chk("rg_gap", {63'd0, ram_enable}, 64'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rg_rv", {63'd0, resp_valid}, 64'd0);
      chk("rg_en", {63'd0, ram_enable}, 64'd0);
      chk("rg_addr", {32'd0, ram_addr}, 64'd0);
      chk("rg_stall", {63'd0, stall}, 64'd0);
      chk("rg_ready", {63'd0, req_ready}, 64'd0);
      chk("rg_rdata", resp_rdata, 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      any_rv = 1'b0;
      @(negedge clk);
      chk("rg_ready_after", {63'd0, req_ready}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         any_rv = any_rv | resp_valid | ram_enable;
         @(negedge clk);
      end
      chk("rg_no_resp", {63'd0, any_rv}, 64'd0);
      do_req(1'b0, 2'b10, 32'h10, 64'd0);
      chk("rg_wl_lat", 64'(lat), 64'd2);
      chk("rg_wl_rdata", rd, 64'hDEADBEEF);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
